fp_msub_unit: RTL and testbench
===============================

// Module: fp_msub_unit
// PURPOSE
//  IEEE-754 binary32 fused multiply-subtract: result = (fp_a * fp_b) - fp_c, with one final rounding.
//  The block is a registered arithmetic unit in the FP ALU, next to the add/mul/madd units.
//  It has a combinational datapath and one output register stage, with a valid-tagged result.
// PARAMETERS
//  none (format fixed: 1 sign, 8 exponent, 23 fraction, bias 127)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operands/r_mode valid this cycle
//  fp_a       in   32  multiplicand (binary32)
//  fp_b       in   32  multiplier (binary32)
//  fp_c       in   32  subtrahend (binary32)
//  r_mode     in   3   000 RNE, 001 RTZ, 010 RDN(-inf), 011 RUP(+inf), 100 RMM; others treated as RNE
//  out_valid  out  1   fp_result/flags valid
//  fp_result  out  32  rounded (a*b)-c
//  overflow   out  1   rounded magnitude exceeded max finite
//  underflow  out  1   nonzero result below min normal (flushed)
// BEHAVIOUR
//  - Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N; the unit accepts a new op every cycle.
//  - out_valid <= in_valid. When in_valid=0, fp_result and flags hold their previous values.
//  - Reset (rst=1 at edge): out_valid=0, fp_result=32'h0, overflow=0, underflow=0.
//    Reset wins over a simultaneous in_valid.
//  - Effective operation: sign_p = sa^sb, sign_c_eff = ~sc, then fused add of product and -c.
//  - Product is exact 48-bit mantissa; alignment keeps guard/round/sticky, so only a single rounding occurs.
//  - Subnormal inputs (exp=0, frac!=0) are treated as signed zero.
//  - Special cases, in priority order:
//    1 any NaN input -> 32'h7fc00000 (canonical quiet NaN), flags 0
//    2 Inf*0 -> 7fc00000
//    3 product Inf and -c Inf with opposite signs (e.g. +Inf*1 - +Inf) -> 7fc00000
//    4 product Inf -> Inf with sign_p; else -c Inf -> Inf with sign ~sc; flags 0
//    5 product zero and c zero -> +0, except -0 when both addends are -0 or when r_mode=RDN
//  - Exact cancellation of nonzero values -> +0 (-0 under RDN).
//  - Normalisation uses a leading-zero count after subtract. Exponent arithmetic is 10-bit signed to catch range errors.
//  - Rounding increments on carry out: renormalise and increment the exponent.
//  - Overflow (exponent >= 255 after rounding) sets overflow=1.
//    Result is Inf for RNE/RMM, for RUP when positive, and for RDN when negative; otherwise max finite 7f7fffff/ff7fffff.
//  - Underflow (nonzero result with exponent < 1) sets underflow=1 and returns a zero carrying the result sign (flush-to-zero).
//  - overflow and underflow are never both 1.
// TESTING
//  - Basic RNE: a=3f800000, b=40000000, c=40400000 -> bf800000 (-1.0).
//  - Basic RNE: a=3f000000, b=40800000, c=3f800000 -> 3f800000.
//  - Basic RNE: a=40000000, b=c0000000, c=40800000 -> c1000000.
//  - Basic RNE: a=bf800000, b=3f800000, c=0 -> bf800000.
//  - Basic RNE: a=40400000, b=40000000, c=c0a00000 -> 41300000.
//  - Infinities: ff800000*40000000 - 7f800000 -> ff800000; 7f800000*3f800000 - 40400000 -> 7f800000.
//  - Invalid: 7f800000*3f800000 - 7f800000 -> 7fc00000; 7f800000*0 - 0 -> 7fc00000.
//  - NaN: 7fc00000*40800000 - 40000000 -> 7fc00000; 3f800000*40000000 - 7fc00000 -> 7fc00000.
//  - Overflow/underflow: 7f000000*40000000 - 0 -> 7f800000 with overflow=1 (RTZ: 7f7fffff);
//    00800000*3f000000 - 0 -> 00000000 with underflow=1.
//  - Control: latency 1 cycle and out_valid tracks in_valid; asserting rst mid-stream clears out_valid and all outputs on the next edge.

Source files
------------

// File: rtl/fp_msub_unit.sv
`default_nettype none
// ============================================================================
// Module   : fp_msub_unit
// Brief    : binary32 fused multiply-subtract (a*b)-c, one rounding, 1-cycle
// Revision : 1.0
// ============================================================================
module fp_msub_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  input  logic [31:0] fp_c,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  output logic [31:0] fp_result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [31:0]       QNAN     = 32'h7fc0_0000;
  localparam logic [2:0]        RM_RNE   = 3'b000;
  localparam logic [2:0]        RM_RTZ   = 3'b001;
  localparam logic [2:0]        RM_RDN   = 3'b010;
  localparam logic [2:0]        RM_RUP   = 3'b011;
  localparam logic [2:0]        RM_RMM   = 3'b100;
  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_MAX  = 10'sd255;

  logic        sa, sb, sc;
  logic [7:0]  ea, eb, ec;
  logic [22:0] fa, fb, fc;

  assign {sa, ea, fa} = fp_a;
  assign {sb, eb, fb} = fp_b;
  assign {sc, ec, fc} = fp_c;

  logic a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_zero, b_zero, c_zero;

  assign a_nan  = (ea == 8'hff) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hff) && (fb != 23'd0);
  assign c_nan  = (ec == 8'hff) && (fc != 23'd0);
  assign a_inf  = (ea == 8'hff) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hff) && (fb == 23'd0);
  assign c_inf  = (ec == 8'hff) && (fc == 23'd0);
  // Subnormals collapse to signed zero on entry.
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign c_zero = (ec == 8'h00);

  logic sign_p, sign_ce, p_inf, p_zero, any_nan, inv_inf_zero;

  assign sign_p       = sa ^ sb;
  assign sign_ce      = ~sc;
  assign p_inf        = a_inf | b_inf;
  assign p_zero       = a_zero | b_zero;
  assign any_nan      = a_nan | b_nan | c_nan;
  assign inv_inf_zero = (a_inf & b_zero) | (a_zero & b_inf);

  logic [2:0] rm;
  assign rm = (r_mode > RM_RMM) ? RM_RNE : r_mode;

  logic [47:0] mp;
  assign mp = 48'({1'b1, fa}) * 48'({1'b1, fb});

  logic signed [9:0] ep, ec_s, big_e, re, re_r;
  logic [9:0]        exp_diff;
  logic [97:0]       p_ext, c_ext, big_m, small_m, small_sh;
  logic              swap, big_s, small_s, sticky, res_s;
  logic [99:0]       big_w, small_w, mag, norm;
  logic [6:0]        lead, lz;
  logic [23:0]       mant;
  logic              guard, st, inc;
  logic [24:0]       mant_r;
  logic [22:0]       mant_f;

  // Both addends live in a 98-bit frame: 48 significand bits (binary point
  // after bit 46 of the product) followed by 50 bits of exact alignment room.
  // Anything shifted beyond that collapses into a single sticky LSB, which
  // is safe because such an addend can only cost one bit of cancellation.
  always_comb begin
    ep       = $signed({2'b00, ea}) + $signed({2'b00, eb}) - EXP_BIAS;
    ec_s     = $signed({2'b00, ec});
    p_ext    = {mp, 50'd0};
    c_ext    = c_zero ? 98'd0 : {2'b01, fc, 73'd0};
    swap     = !c_zero && (ec_s > ep);
    big_e    = swap ? ec_s : ep;
    exp_diff = $unsigned(swap ? (ec_s - ep) : (ep - ec_s));
    big_m    = swap ? c_ext : p_ext;
    small_m  = swap ? p_ext : c_ext;
    big_s    = swap ? sign_ce : sign_p;
    small_s  = swap ? sign_p : sign_ce;
    small_sh = small_m >> exp_diff;
    sticky   = |(small_m & ~({98{1'b1}} << exp_diff));
    big_w    = {1'b0, big_m, 1'b0};
    small_w  = {1'b0, small_sh, sticky};

    if (big_s == small_s) begin
      mag   = big_w + small_w;
      res_s = big_s;
    end else if (big_w >= small_w) begin
      mag   = big_w - small_w;
      res_s = big_s;
    end else begin
      mag   = small_w - big_w;
      res_s = small_s;
    end

    lead = 7'd0;
    for (int i = 0; i < 100; i++) begin
      if (mag[i]) lead = 7'(i);
    end
    lz    = 7'd99 - lead;
    norm  = mag << lz;
    mant  = norm[99:76];
    guard = norm[75];
    st    = |norm[74:0];

    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = res_s & (guard | st);
      RM_RUP:  inc = ~res_s & (guard | st);
      RM_RMM:  inc = guard;
      default: inc = guard & (st | mant[0]);
    endcase

    // Window bit 97 carries weight 2^(big_e-127); a leading one at bit 99-lz
    // therefore puts the result exponent at big_e + 2 - lz.
    mant_r = {1'b0, mant} + {24'd0, inc};
    re     = big_e + 10'sd2 - $signed({3'b000, lz});
    if (mant_r[24]) begin
      re_r   = re + 10'sd1;
      mant_f = mant_r[23:1];
    end else begin
      re_r   = re;
      mant_f = mant_r[22:0];
    end
  end

  logic [31:0] res_calc;
  logic        ovf_calc, udf_calc, to_inf;

  always_comb begin
    res_calc = 32'd0;
    ovf_calc = 1'b0;
    udf_calc = 1'b0;
    to_inf   = (rm == RM_RNE) || (rm == RM_RMM) ||
               ((rm == RM_RUP) && !res_s) || ((rm == RM_RDN) && res_s);

    if (any_nan || inv_inf_zero || (p_inf && c_inf && (sign_p != sign_ce))) begin
      res_calc = QNAN;
    end else if (p_inf) begin
      res_calc = {sign_p, 8'hff, 23'd0};
    end else if (c_inf) begin
      res_calc = {sign_ce, 8'hff, 23'd0};
    end else if (p_zero && c_zero) begin
      res_calc = {(sign_p & sign_ce) | (rm == RM_RDN), 31'd0};
    end else if (p_zero) begin
      res_calc = {sign_ce, fp_c[30:0]};
    end else if (mag == 100'd0) begin
      res_calc = {rm == RM_RDN, 31'd0};
    end else if (re_r >= EXP_MAX) begin
      ovf_calc = 1'b1;
      res_calc = to_inf ? {res_s, 8'hff, 23'd0} : {res_s, 8'hfe, 23'h7f_ffff};
    end else if (re_r < 10'sd1) begin
      udf_calc = 1'b1;
      res_calc = {res_s, 31'd0};
    end else begin
      res_calc = {res_s, re_r[7:0], mant_f};
    end
  end

  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (in_valid) begin
      result_d    = res_calc;
      overflow_d  = ovf_calc;
      underflow_d = udf_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign fp_result = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_msub_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_msub_unit
// Brief    : exact fixed-point reference model bench for fp_msub_unit
// Revision : 1.0
// ============================================================================
module tb_fp_msub_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] fp_a, fp_b, fp_c;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic [31:0] fp_result;
  logic        overflow, underflow;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        un;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [2:0]  rm;
    logic [31:0] r;
    logic        ov;
    logic        un;
  } vec_t;

  always #5 clk = ~clk;

  fp_msub_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .fp_c      (fp_c),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .fp_result (fp_result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // The exact value a*b - c is an integer multiple of 2^-298; the model forms
  // it in a 600-bit integer and rounds it once to 24 significant bits.
  function automatic res_t ref_msub(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c, input logic [2:0] rm_in);
    res_t         o;
    logic [2:0]   rm;
    logic         sp, sce, sg, g, st, up, to_inf;
    logic         a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_z, b_z, c_z, p_inf, p_z;
    logic [599:0] pm, cm, mag;
    logic [23:0]  m;
    logic [24:0]  mm;
    int           k, e;
    o     = '0;
    rm    = (rm_in > 3'd4) ? 3'd0 : rm_in;
    sp    = a[31] ^ b[31];
    sce   = ~c[31];
    a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    c_nan = (c[30:23] == 8'hff) && (c[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    c_inf = (c[30:23] == 8'hff) && (c[22:0] == 23'd0);
    a_z   = (a[30:23] == 8'h00);
    b_z   = (b[30:23] == 8'h00);
    c_z   = (c[30:23] == 8'h00);
    p_inf = a_inf | b_inf;
    p_z   = a_z | b_z;
    if (a_nan || b_nan || c_nan) o.res = 32'h7fc00000;
    else if (p_inf && p_z) o.res = 32'h7fc00000;
    else if (p_inf && c_inf && (sp != sce)) o.res = 32'h7fc00000;
    else if (p_inf) o.res = {sp, 8'hff, 23'd0};
    else if (c_inf) o.res = {sce, 8'hff, 23'd0};
    else if (p_z && c_z) o.res = {(sp & sce) | (rm == 3'd2), 31'd0};
    else if (p_z) o.res = {sce, c[30:0]};
    else begin
      pm = 600'(48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]}));
      pm = pm << (int'(a[30:23]) + int'(b[30:23]) - 2);
      cm = c_z ? '0 : (600'({1'b1, c[22:0]}) << (int'(c[30:23]) + 148));
      if (sp == sce) begin mag = pm + cm; sg = sp; end
      else if (pm >= cm) begin mag = pm - cm; sg = sp; end
      else begin mag = cm - pm; sg = sce; end
      if (mag == '0) begin
        o.res = {rm == 3'd2, 31'd0};
      end else begin
        k = 0;
        for (int i = 0; i < 600; i++) if (mag[i]) k = i;
        m  = mag[k -: 24];
        g  = mag[k - 24];
        st = 1'b0;
        for (int i = 0; i < k - 24; i++) st = st | mag[i];
        case (rm)
          3'd1:    up = 1'b0;
          3'd2:    up = sg & (g | st);
          3'd3:    up = !sg & (g | st);
          3'd4:    up = g;
          default: up = g & (st | m[0]);
        endcase
        e  = k - 171;
        mm = {1'b0, m} + 25'(up);
        if (mm[24]) begin e = e + 1; m = 24'h800000; end
        else m = mm[23:0];
        to_inf = (rm == 3'd0) || (rm == 3'd4) || ((rm == 3'd3) && !sg) || ((rm == 3'd2) && sg);
        if (e >= 255) begin
          o.ov  = 1'b1;
          o.res = to_inf ? {sg, 8'hff, 23'd0} : {sg, 8'hfe, 23'h7fffff};
        end else if (e < 1) begin
          o.un  = 1'b1;
          o.res = {sg, 31'd0};
        end else begin
          o.res = {sg, 8'(e), m[22:0]};
        end
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (a=%08h b=%08h c=%08h rm=%0d)",
               name, act, expv, fp_a, fp_b, fp_c, r_mode);
    end
  endtask

  res_t exp_q     = '0;
  logic exp_valid = 1'b0;
  logic chk_en    = 1'b0;

  always @(posedge clk) begin
    chk_en <= 1'b1;
    if (rst) begin
      exp_valid <= 1'b0;
      exp_q     <= '0;
    end else begin
      exp_valid <= in_valid;
      if (in_valid) exp_q <= ref_msub(fp_a, fp_b, fp_c, r_mode);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("fp_result", fp_result, exp_q.res);
      check("overflow", {31'd0, overflow}, {31'd0, exp_q.ov});
      check("underflow", {31'd0, underflow}, {31'd0, exp_q.un});
      check("flag_excl", {31'd0, overflow & underflow}, 32'd0);
    end
  end

  function automatic logic [22:0] rnd_frac();
    case ($urandom_range(0, 2))
      0:       return 23'($urandom) & 23'($urandom);
      1:       return 23'h7fffff - 23'($urandom_range(0, 7));
      default: return 23'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rnd_special();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       return {s, 31'd0};
      1:       return {s, 8'hff, 23'd0};
      2:       return {s, 8'hff, 23'($urandom_range(1, 32'h7fffff))};
      3:       return {s, 8'h00, 23'($urandom_range(1, 32'h7fffff))};
      4:       return {s, 8'hfe, 23'h7fffff};
      default: return {s, 8'h7f, 23'd0};
    endcase
  endfunction

  task automatic gen_op();
    int ea, eb, ec, kind;
    kind = $urandom_range(0, 9);
    case (kind)
      0:       begin ea = $urandom_range(190, 254); eb = $urandom_range(190, 254); end
      1:       begin ea = $urandom_range(1, 70);    eb = $urandom_range(1, 70);    end
      default: begin ea = $urandom_range(100, 154); eb = $urandom_range(100, 154); end
    endcase
    fp_a = {1'($urandom), 8'(ea), rnd_frac()};
    fp_b = {1'($urandom), 8'(eb), rnd_frac()};
    ec   = ea + eb - 127 + int'($urandom_range(0, 60)) - 30;
    if (ec < 1) ec = 1;
    if (ec > 254) ec = 254;
    fp_c = {1'($urandom), 8'(ec), rnd_frac()};
    if (kind == 2) begin
      fp_b = 32'h3f800000;
      fp_c = {fp_a[31], fp_a[30:0] ^ 31'($urandom_range(0, 3))};
    end else if (kind == 3) begin
      case ($urandom_range(0, 2))
        0:       fp_a = rnd_special();
        1:       fp_b = rnd_special();
        default: fp_c = rnd_special();
      endcase
    end else if (kind == 4) begin
      fp_a = {1'($urandom), 31'd0};
    end
    r_mode = 3'($urandom_range(0, 7));
  endtask

  initial begin
    vec_t vecs[20];
    res_t r;
    rst = 1'b1; in_valid = 1'b0; fp_a = '0; fp_b = '0; fp_c = '0; r_mode = '0;
    vecs[0]  = '{32'h3f800000, 32'h40000000, 32'h40400000, 3'd0, 32'hbf800000, 1'b0, 1'b0};
    vecs[1]  = '{32'h3f000000, 32'h40800000, 32'h3f800000, 3'd0, 32'h3f800000, 1'b0, 1'b0};
    vecs[2]  = '{32'h40000000, 32'hc0000000, 32'h40800000, 3'd0, 32'hc1000000, 1'b0, 1'b0};
    vecs[3]  = '{32'hbf800000, 32'h3f800000, 32'h00000000, 3'd0, 32'hbf800000, 1'b0, 1'b0};
    vecs[4]  = '{32'h40400000, 32'h40000000, 32'hc0a00000, 3'd0, 32'h41300000, 1'b0, 1'b0};
    vecs[5]  = '{32'hff800000, 32'h40000000, 32'h7f800000, 3'd0, 32'hff800000, 1'b0, 1'b0};
    vecs[6]  = '{32'h7f800000, 32'h3f800000, 32'h40400000, 3'd0, 32'h7f800000, 1'b0, 1'b0};
    vecs[7]  = '{32'h7f800000, 32'h3f800000, 32'h7f800000, 3'd0, 32'h7fc00000, 1'b0, 1'b0};
    vecs[8]  = '{32'h7f800000, 32'h00000000, 32'h00000000, 3'd0, 32'h7fc00000, 1'b0, 1'b0};
    vecs[9]  = '{32'h7fc00000, 32'h40800000, 32'h40000000, 3'd0, 32'h7fc00000, 1'b0, 1'b0};
    vecs[10] = '{32'h3f800000, 32'h40000000, 32'h7fc00000, 3'd0, 32'h7fc00000, 1'b0, 1'b0};
    vecs[11] = '{32'h7f000000, 32'h40000000, 32'h00000000, 3'd0, 32'h7f800000, 1'b1, 1'b0};
    vecs[12] = '{32'h7f000000, 32'h40000000, 32'h00000000, 3'd1, 32'h7f7fffff, 1'b1, 1'b0};
    vecs[13] = '{32'h00800000, 32'h3f000000, 32'h00000000, 3'd0, 32'h00000000, 1'b0, 1'b1};
    vecs[14] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 3'd2, 32'h80000000, 1'b0, 1'b0};
    vecs[15] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 3'd0, 32'h00000000, 1'b0, 1'b0};
    vecs[16] = '{32'h00000000, 32'h00000000, 32'h00000000, 3'd2, 32'h80000000, 1'b0, 1'b0};
    vecs[17] = '{32'h3f800001, 32'h3f800001, 32'h00000000, 3'd3, 32'h3f800003, 1'b0, 1'b0};
    vecs[18] = '{32'h3f800001, 32'h3f800001, 32'h00000000, 3'd0, 32'h3f800002, 1'b0, 1'b0};
    vecs[19] = '{32'h00000001, 32'h40000000, 32'h3f800000, 3'd0, 32'hbf800000, 1'b0, 1'b0};

    foreach (vecs[i]) begin
      r = ref_msub(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].rm);
      check("model_res", r.res, vecs[i].r);
      check("model_ov", {31'd0, r.ov}, {31'd0, vecs[i].ov});
      check("model_un", {31'd0, r.un}, {31'd0, vecs[i].un});
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    foreach (vecs[i]) begin
      fp_a = vecs[i].a; fp_b = vecs[i].b; fp_c = vecs[i].c; r_mode = vecs[i].rm;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 4000; n++) begin
      gen_op();
      in_valid = ($urandom_range(0, 7) != 0);
      rst      = ((n % 1000) == 999);
      @(posedge clk); #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
